// File: rtl/uc_mult_sumdesp.sv
// -----------------------------------------------------------------------------
// uc_mult_sumdesp
//
// Hardwired control unit for a sequential shift-and-add unsigned multiplier.
// The datapath it steers holds an accumulator A, a multiplier register Q and a
// multiplicand register M.  This block never sees operand data: it only reads
// the LSB of Q and a start request, and it produces the load/clear/shift
// enables for the three registers.  Internally it is a Moore FSM plus a small
// iteration counter.
//
// Optional build macro:
//   UCMULT_FIN_PULSE_EN  - when defined, DONE lasts exactly one cycle (fin is a
//                          single-cycle pulse) and the unit always returns to
//                          IDLE, so a start held high launches the next
//                          operation back-to-back.  When undefined, fin is held
//                          until start drops (four-phase handshake).
//
// Parameters:
//   N    operand width = number of add/shift iterations (N >= 2)
//   CW   iteration counter width, 2**CW >= N
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset)
//   start      level request to begin a multiplication
//   q0         current Q[0] from the Q register
//   CargaM     load multiplicand register M
//   CargaQ     load Q with the external operand
//   LimpiaA    clear accumulator A
//   CargaA     load A with A+M
//   DesplazaA  shift A right (A[0] feeds Q's top bit in the datapath)
//   DesplazaQ  shift Q right
//   fin        product valid in A:Q
// -----------------------------------------------------------------------------
module uc_mult_sumdesp #(
   parameter int N  = 3,
   parameter int CW = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic q0,
   output logic CargaM,
   output logic CargaQ,
   output logic LimpiaA,
   output logic CargaA,
   output logic DesplazaA,
   output logic DesplazaQ,
   output logic fin
);

   // Six legal states; encodings 6 and 7 are unused and recover to IDLE.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_TEST  = 3'd2,
      S_ADD   = 3'd3,
      S_SHIFT = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Value of the counter during the last SHIFT of an operation.
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_next;
   logic            cnt_en;

   // State register.  The reset is asynchronous so the outputs, which are
   // decoded only from this register, drop to zero as soon as reset asserts,
   // even in the middle of an operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Iteration counter, a separate register with its own enable.  It only
   // changes in LOAD (cleared) and SHIFT (incremented, or cleared on the
   // last iteration), so it never exceeds N-1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (cnt_en) begin
         cnt <= cnt_next;
      end
   end

   // Next-state and counter-update logic.  start is looked at only in IDLE
   // and DONE, and q0 only in TEST, so toggling either input elsewhere
   // cannot disturb a running operation.
   always_comb begin
      state_next = S_IDLE;
      cnt_en     = 1'b0;
      cnt_next   = cnt;
      case (state)
         S_IDLE: begin
            state_next = start ? S_LOAD : S_IDLE;
         end
         S_LOAD: begin
            cnt_en     = 1'b1;
            cnt_next   = '0;
            state_next = S_TEST;
         end
         S_TEST: begin
            state_next = q0 ? S_ADD : S_SHIFT;
         end
         S_ADD: begin
            state_next = S_SHIFT;
         end
         S_SHIFT: begin
            cnt_en = 1'b1;
            if (cnt == CNT_LAST) begin
               cnt_next   = '0;
               state_next = S_DONE;
            end else begin
               cnt_next   = cnt + CW'(1);
               state_next = S_TEST;
            end
         end
         S_DONE: begin
`ifdef UCMULT_FIN_PULSE_EN
            state_next = S_IDLE;
`else
            state_next = start ? S_DONE : S_IDLE;
`endif
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Moore output decode.  Every output depends on the state register alone,
   // so there is no combinational path from start or q0 to any output, and
   // the ADD/SHIFT split guarantees CargaA never overlaps the shifts.
   always_comb begin
      CargaM    = 1'b0;
      CargaQ    = 1'b0;
      LimpiaA   = 1'b0;
      CargaA    = 1'b0;
      DesplazaA = 1'b0;
      DesplazaQ = 1'b0;
      fin       = 1'b0;
      case (state)
         S_LOAD: begin
            CargaM  = 1'b1;
            CargaQ  = 1'b1;
            LimpiaA = 1'b1;
         end
         S_ADD: begin
            CargaA = 1'b1;
         end
         S_SHIFT: begin
            DesplazaA = 1'b1;
            DesplazaQ = 1'b1;
         end
         S_DONE: begin
            fin = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_uc_mult_sumdesp.sv
// -----------------------------------------------------------------------------
// tb_uc_mult_sumdesp
//
// Self-checking bench for the shift-and-add multiplier control unit (N=3).
// The bench keeps its own model of the A/Q/M datapath, driven by the enables
// the control unit produces, and feeds the modelled Q[0] back as q0.  The
// expected enable trace for each operation is generated from the operand
// bits (LOAD, then per bit TEST [+ADD] SHIFT, then DONE), and the final A:Q
// contents are compared with the arithmetic product M*Q.
// Build with +define+UCMULT_FIN_PULSE_EN to exercise the pulsed-fin variant.
// -----------------------------------------------------------------------------
module tb_uc_mult_sumdesp;

   localparam int N  = 3;
   localparam int CW = 2;

   // Output vector layout: {CargaM,CargaQ,LimpiaA,CargaA,DesplazaA,DesplazaQ,fin}
   localparam logic [6:0] O_IDLE  = 7'b0000000;
   localparam logic [6:0] O_LOAD  = 7'b1110000;
   localparam logic [6:0] O_TEST  = 7'b0000000;
   localparam logic [6:0] O_ADD   = 7'b0001000;
   localparam logic [6:0] O_SHIFT = 7'b0000110;
   localparam logic [6:0] O_DONE  = 7'b0000001;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic q0;
   logic CargaM, CargaQ, LimpiaA, CargaA, DesplazaA, DesplazaQ, fin;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [6:0] outs;
      bit         is_test;
   } step_t;

   typedef struct {
      logic [N-1:0] qv;
      logic [N-1:0] mv;
      int           lat;
      int           adds;
   } vec_t;

   step_t exp_q[$];

   // Behavioural datapath model
   logic [N:0]   m_a;
   logic [N-1:0] m_q;
   logic [N-1:0] m_m;
   logic [N-1:0] op_q;
   logic [N-1:0] op_m;

   uc_mult_sumdesp #(.N(N), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .q0        (q0),
      .CargaM    (CargaM),
      .CargaQ    (CargaQ),
      .LimpiaA   (LimpiaA),
      .CargaA    (CargaA),
      .DesplazaA (DesplazaA),
      .DesplazaQ (DesplazaQ),
      .fin       (fin)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Global time limit so the bench always ends on its own
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [6:0] out_vec();
      return {CargaM, CargaQ, LimpiaA, CargaA, DesplazaA, DesplazaQ, fin};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Expected enable trace derived from the operand bits, LSB first
   function automatic void build_trace(input logic [N-1:0] qv);
      exp_q.delete();
      exp_q.push_back('{O_LOAD, 1'b0});
      for (int i = 0; i < N; i++) begin
         exp_q.push_back('{O_TEST, 1'b1});
         if (qv[i]) exp_q.push_back('{O_ADD, 1'b0});
         exp_q.push_back('{O_SHIFT, 1'b0});
      end
      exp_q.push_back('{O_DONE, 1'b0});
   endfunction

   // Apply the enables seen this cycle to the datapath model
   task automatic apply_datapath(input logic [6:0] o);
      logic [2*N:0] aq;
      if (o[6]) m_m = op_m;
      if (o[5]) m_q = op_q;
      if (o[4]) m_a = '0;
      if (o[3]) m_a = m_a + {1'b0, m_m};
      if (o[2] && o[1]) begin
         aq  = {m_a, m_q} >> 1;
         m_a = aq[2*N:N];
         m_q = aq[N-1:0];
      end
   endtask

   task automatic recover();
      start = 1'b0;
      reset = 1'b0;
      #3;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Run one multiplication from IDLE (called #1 after a rising edge with the
   // DUT idle).  noise randomises start and q0 wherever they must be ignored.
   // hold keeps start high after DONE (back-to-back in the pulsed build).
   task automatic applyStimulus(input logic [N-1:0] qv, input logic [N-1:0] mv,
                                input bit noise, input bit hold, input string tag,
                                output int lat, output int adds);
      logic [6:0] o;
      int         k;
      int         fin_idx;
      int         want_p;
      bit         is_test;
      build_trace(qv);
      op_q    = qv;
      op_m    = mv;
      fin_idx = -1;
      adds    = 0;
      k       = 0;
      start   = 1'b1;
      while (k < 40 && fin_idx < 0) begin
         @(posedge clk);
         #1;
         o = out_vec();
         if (k < exp_q.size()) begin
            checkOutput($sformatf("%s trace[%0d]", tag, k), 32'(o), 32'(exp_q[k].outs));
            is_test = exp_q[k].is_test;
         end else begin
            checkOutput($sformatf("%s overrun[%0d]", tag, k), 32'(o), 32'(O_DONE));
            is_test = 1'b0;
         end
         checkOutput($sformatf("%s overlap[%0d]", tag, k), 32'(CargaA & DesplazaA), 32'd0);
         if (CargaA) adds++;
         if (fin) fin_idx = k;
         q0 = (noise && !is_test) ? 1'($urandom) : m_q[0];
         apply_datapath(o);
         start = noise ? 1'($urandom) : 1'b1;
         k++;
      end
      lat = fin_idx;
      if (fin_idx < 0) begin
         $display("[TB] FAIL %s fin timeout: got none want fin within 40 cycles", tag);
         total++;
         bad++;
         recover();
         return;
      end
      want_p = int'(mv) * int'(qv);
      checkOutput({tag, " product"}, 32'({m_a[N-1:0], m_q}), 32'(want_p));
`ifdef UCMULT_FIN_PULSE_EN
      start = hold;
      @(posedge clk);
      #1;
      checkOutput({tag, " idle after pulse"}, 32'(out_vec()), 32'(O_IDLE));
`else
      start = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("%s fin held[%0d]", tag, c), 32'(out_vec()), 32'(O_DONE));
      end
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, " idle after drop"}, 32'(out_vec()), 32'(O_IDLE));
      start = hold;
`endif
   endtask

   initial begin
      vec_t       vecs[6];
      int         lat;
      int         adds;
      int         exp_lat;
      logic [N-1:0] rq;
      logic [N-1:0] rm;
      bit         found;

      vecs[0] = '{3'b101, 3'd7, 9,  2};
      vecs[1] = '{3'b000, 3'd5, 7,  0};
      vecs[2] = '{3'b111, 3'd7, 10, 3};
      vecs[3] = '{3'b001, 3'd6, 8,  1};
      vecs[4] = '{3'b110, 3'd3, 9,  2};
      vecs[5] = '{3'b010, 3'd4, 8,  1};

      // Reset state: outputs zero while reset is low
      reset = 1'b1;
      start = 1'b0;
      q0    = 1'b0;
      m_a   = '0;
      m_q   = '0;
      m_m   = '0;
      #1 reset = 1'b0;
      #1;
      checkOutput("reset outputs", 32'(out_vec()), 32'(O_IDLE));
      @(posedge clk);
      #1;
      checkOutput("reset outputs held", 32'(out_vec()), 32'(O_IDLE));
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("idle after reset[%0d]", c), 32'(out_vec()), 32'(O_IDLE));
      end

      // Directed operand table
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].qv, vecs[i].mv, 1'b0, 1'b0, $sformatf("vec%0d", i), lat, adds);
         checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         checkOutput($sformatf("vec%0d adds", i), 32'(adds), 32'(vecs[i].adds));
      end

      // 3'b101 with start and q0 toggled wherever they must be ignored
      applyStimulus(3'b101, 3'd6, 1'b1, 1'b0, "noisy101", lat, adds);
      checkOutput("noisy101 latency", 32'(lat), 32'd9);
      checkOutput("noisy101 adds", 32'(adds), 32'd2);

      // Reset asserted in the middle of a SHIFT cycle
      start = 1'b1;
      q0    = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(posedge clk);
         #1;
         if (DesplazaQ) found = 1'b1;
      end
      checkOutput("reach shift", 32'(found), 32'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("reset mid shift", 32'(out_vec()), 32'(O_IDLE));
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("idle after mid reset", 32'(out_vec()), 32'(O_IDLE));

      // Reset asserted during LOAD
      start = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("load before reset", 32'(out_vec()), 32'(O_LOAD));
      #2 reset = 1'b0;
      #1;
      checkOutput("reset in load", 32'(out_vec()), 32'(O_IDLE));
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Randomised operations against the arithmetic model
      for (int r = 0; r < 20; r++) begin
         rq = N'($urandom);
         rm = N'($urandom);
         exp_lat = 1;
         for (int b = 0; b < N; b++) exp_lat += rq[b] ? 3 : 2;
         applyStimulus(rq, rm, 1'($urandom), 1'b0, $sformatf("rand%0d", r), lat, adds);
         checkOutput($sformatf("rand%0d latency", r), 32'(lat), 32'(exp_lat));
         checkOutput($sformatf("rand%0d adds", r), 32'(adds), 32'($countones(rq)));
      end

`ifdef UCMULT_FIN_PULSE_EN
      // Start held high: fin pulses, IDLE for one cycle, then LOAD again
      applyStimulus(3'b011, 3'd5, 1'b0, 1'b1, "b2b_first", lat, adds);
      checkOutput("b2b_first latency", 32'(lat), 32'd9);
      applyStimulus(3'b100, 3'd7, 1'b0, 1'b0, "b2b_second", lat, adds);
      checkOutput("b2b_second latency", 32'(lat), 32'd8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uc_mult_sumdesp.md
Name: uc_mult_sumdesp

Overview:
- Hardwired control unit for the sequential shift-and-add unsigned multiplier datapath (accumulator A, multiplier register Q, multiplicand register M).
- Drives the load/shift enables of the Q register and its neighbours.
- Reads only the LSB of Q and the external start request.
- Holds no operand data: a Moore FSM plus an iteration counter.

Parameters:
- N, 3, operand width = number of add/shift iterations (N >= 2).
- CW, 2, iteration counter width; integrator guarantees 2^CW >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  level request to begin a multiplication.
- q0  input  1  current Q[0] from the Q register.
- CargaM  output  1  load multiplicand register M.
- CargaQ  output  1  load Q with external operand.
- LimpiaA  output  1  clear accumulator A.
- CargaA  output  1  load A with A+M.
- DesplazaA  output  1  shift A right (A[0] feeds Q's top bit in the datapath).
- DesplazaQ  output  1  shift Q right.
- fin  output  1  product valid in A:Q.

Behaviour:
- Moore outputs, decoded from the state register only. No combinational path from start/q0 to any output.
- Reset (reset=0, asynchronous) forces state IDLE and cnt=0; all outputs 0 immediately. This holds mid-operation too; the datapath content is then don't-care.
- States:
  - IDLE: all outputs 0. start=1 sampled at the edge -> LOAD. Otherwise stay.
  - LOAD: CargaM=CargaQ=LimpiaA=1 for exactly one cycle; cnt<=0 -> TEST.
  - TEST: all outputs 0. q0=1 -> ADD, q0=0 -> SHIFT. q0 is sampled only in this state.
  - ADD: CargaA=1 for one cycle -> SHIFT.
  - SHIFT: DesplazaA=DesplazaQ=1 for one cycle.
    - cnt==N-1 -> DONE, cnt<=0.
    - else cnt<=cnt+1 -> TEST.
  - DONE: fin=1; other outputs 0. Stays while start=1; start=0 -> IDLE (four-phase handshake).
- Exactly N SHIFT cycles per operation. CargaA and DesplazaA/Q are never asserted in the same cycle.
- start is ignored in every state except IDLE and DONE. Raising or dropping it during LOAD..SHIFT has no effect.
- Latency from the edge that samples start in IDLE to the edge entering DONE: 1 + sum over iterations of (2 if q0=0, 3 if q0=1). Range 1+2N .. 1+3N.
- Counter wraps only via explicit reset to 0 at the end; it never exceeds N-1.
- Unused or illegal state encodings go to IDLE on the next edge with outputs 0.
- Implemented as a state register plus next-state and output logic using the team's flip-flop primitives. The counter is a separate CW-bit register with enable.

Optional Feature:
- Macro UCMULT_FIN_PULSE_EN.
- Defined: DONE lasts exactly one cycle (fin is a 1-cycle pulse) and always goes to IDLE. If start is still 1 in that following IDLE cycle, a new operation starts (back-to-back).
- Undefined: four-phase behaviour above, with fin held until start=0.

Test Plan:
- Reset: reset=0 in any state (including mid-SHIFT) -> all outputs 0 immediately. With start=0 after release, remains IDLE for 10 cycles.
- N=3, bench models Q=3'b101 (q0 sequence 1,0,1), start=1 at edge 0:
  - LOAD after edge 0; CargaA after edges 2 and 7; shifts after edges 3, 5, 8.
  - fin=1 after edge 9; held until start=0, then IDLE next edge.
- N=3, Q=3'b000: no CargaA ever; 3 shift cycles; fin after edge 7.
- N=3, Q=3'b111: 3 CargaA and 3 shift cycles, strictly alternating; fin after edge 10.
- Toggle start and q0 randomly outside TEST during an operation -> sequence identical to the clean 3'b101 run.
- With UCMULT_FIN_PULSE_EN and start held 1: fin high one cycle, then IDLE, then LOAD on the following edge. Two complete operations observed back-to-back.
